tdes: RTL and testbench



---
 rtl/tdes_pkg.sv | 93 +++++++++
 rtl/des_round.sv | 17 +
 rtl/tdes.sv | 118 +++++++++++
 tb/tb_tdes.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdes_pkg.sv
// Shared DES tables, FSM state type and bit-level helper functions for the tdes core.
// Bit numbering follows FIPS 46-3: bit 1 is the MSB of every vector.
package tdes_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam int unsigned IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int unsigned FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int unsigned E_T [48] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int unsigned P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int unsigned PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int unsigned PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // LSH_T: left rotate before each encrypt round; RSH_T: right rotate before each decrypt round
  localparam int unsigned LSH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int unsigned RSH_T [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  localparam int unsigned SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [1:64] ip(input logic [1:64] v);
    logic [1:64] o;
    for (int unsigned i = 1; i <= 64; i++) o[i] = v[IP_T[i-1]];
    return o;
  endfunction

  function automatic logic [1:64] fp(input logic [1:64] v);
    logic [1:64] o;
    for (int unsigned i = 1; i <= 64; i++) o[i] = v[FP_T[i-1]];
    return o;
  endfunction

  function automatic logic [1:56] pc1(input logic [1:64] key);
    logic [1:56] o;
    for (int unsigned i = 1; i <= 56; i++) o[i] = key[PC1_T[i-1]];
    return o;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] o;
    for (int unsigned i = 1; i <= 48; i++) o[i] = cd[PC2_T[i-1]];
    return o;
  endfunction

  function automatic logic [1:28] rot(input logic [1:28] v, input logic left, input int unsigned n);
    logic [1:28] o;
    o = v;
    if (n == 1)      o = left ? {v[2:28], v[1]}   : {v[28], v[1:27]};
    else if (n == 2) o = left ? {v[3:28], v[1:2]} : {v[27:28], v[1:26]};
    return o;
  endfunction

  function automatic logic [1:32] f(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s, o;
    logic [1:6]  b;
    for (int unsigned i = 1; i <= 48; i++) x[i] = r[E_T[i-1]];
    x = x ^ k;
    // S-box address: row = outer bits {b1,b6}, column = inner bits b2..b5
    for (int unsigned j = 0; j < 8; j++) begin
      b = x[j*6+1 +: 6];
      s[j*4+1 +: 4] = 4'(SBOX[j][{b[1], b[6], b[2:5]}]);
    end
    for (int unsigned i = 1; i <= 32; i++) o[i] = s[P_T[i-1]];
    return o;
  endfunction

endpackage

// File: rtl/des_round.sv
// Combinational single DES Feistel round.
module des_round
  import tdes_pkg::*;
(
  input  logic [1:32] l,
  input  logic [1:32] r,
  input  logic [1:48] k,
  output logic [1:32] l_next,
  output logic [1:32] r_next
);

  always_comb begin
    l_next = r;
    r_next = l ^ f(r, k);
  end

endmodule

// File: rtl/tdes.sv
// Iterative Triple-DES core: one Feistel round per enabled clock, 48 rounds per block.
module tdes
  import tdes_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [1:64] Din,
  input  logic [1:64] Key1,
  input  logic [1:64] Key2,
  input  logic [1:64] Key3,
  input  logic        Krdy,
  input  logic        Drdy,
  input  logic        ENC,
  output logic [1:64] Dout,
  output logic        BSY,
  output logic        Dvld
);

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [1:0]  stage;
  logic [3:0]  rnd;
  logic        enc, stage_enc, last;
  logic [1:64] k1, k2, k3, start_key, next_key;
  logic [1:28] c, d, c_cur, d_cur;
  logic [1:32] l, r, l_nx, r_nx;
  logic [1:48] subkey;

  des_round u_round (
    .l      (l),
    .r      (r),
    .k      (subkey),
    .l_next (l_nx),
    .r_next (r_nx)
  );

  always_ff @(posedge CLK) begin
    if (RST)     state <= ST_IDLE;
    else if (EN) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (Drdy) state_nx = ST_BUSY;
      ST_BUSY: if (last) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    BSY = (state == ST_BUSY);
  end

  // Stage 1 always runs the opposite direction of the requested operation.
  always_comb begin
    stage     = cnt[5:4];
    rnd       = cnt[3:0];
    last      = (cnt == 6'd47);
    stage_enc = enc ^ (stage == 2'd1);
    start_key = ENC ? (Krdy ? Key1 : k1) : (Krdy ? Key3 : k3);
    case (stage)
      2'd0:    next_key = k2;
      2'd1:    next_key = enc ? k3 : k1;
      default: next_key = k2;
    endcase
    c_cur  = rot(c, stage_enc, stage_enc ? LSH_T[rnd] : RSH_T[rnd]);
    d_cur  = rot(d, stage_enc, stage_enc ? LSH_T[rnd] : RSH_T[rnd]);
    subkey = pc2({c_cur, d_cur});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      k1   <= '0;
      k2   <= '0;
      k3   <= '0;
      enc  <= 1'b0;
      cnt  <= '0;
      l    <= '0;
      r    <= '0;
      c    <= '0;
      d    <= '0;
      Dout <= '0;
      Dvld <= 1'b0;
    end else if (EN) begin
      Dvld <= 1'b0;
      if (!BSY) begin
        if (Krdy) begin
          k1 <= Key1;
          k2 <= Key2;
          k3 <= Key3;
        end
        if (Drdy) begin
          {l, r} <= ip(Din);
          {c, d} <= pc1(start_key);
          enc    <= ENC;
          cnt    <= '0;
        end
      end else if (last) begin
        Dout <= fp({r_nx, l_nx});
        Dvld <= 1'b1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 6'd1;
        // Swap at stage end cancels the DES final swap; FP/IP between stages is an identity.
        if (rnd == 4'd15) begin
          {l, r} <= {r_nx, l_nx};
          {c, d} <= pc1(next_key);
        end else begin
          {l, r} <= {l_nx, r_nx};
          {c, d} <= {c_cur, d_cur};
        end
      end
    end
  end

endmodule

// File: tb/tb_tdes.sv
// Self-checking bench for tdes: transaction-level TDEA model checked every cycle plus known-answer vectors.
module tb_tdes;
  import tdes_pkg::*;

  logic        CLK, RST, EN, Krdy, Drdy, ENC;
  logic [1:64] Din, Key1, Key2, Key3, Dout;
  logic        BSY, Dvld;

  int checks = 0;
  int errors = 0;

  tdes dut (
    .CLK (CLK), .RST (RST), .EN (EN), .Din (Din),
    .Key1 (Key1), .Key2 (Key2), .Key3 (Key3),
    .Krdy (Krdy), .Drdy (Drdy), .ENC (ENC),
    .Dout (Dout), .BSY (BSY), .Dvld (Dvld)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Textbook single DES: full subkey list first, reversed order for decryption.
  function automatic logic [1:64] des(input logic [1:64] blk, input logic [1:64] key, input bit e);
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] ks [16];
    logic [1:48] t;
    logic [1:64] x, pre, o;
    logic [1:32] lh, rh, sv, fo;
    int unsigned row, col;
    for (int unsigned i = 1; i <= 56; i++) cd[i] = key[PC1_T[i-1]];
    c = cd[1:28];
    d = cd[29:56];
    for (int unsigned n = 0; n < 16; n++) begin
      for (int unsigned s = 0; s < LSH_T[n]; s++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      cd = {c, d};
      for (int unsigned i = 1; i <= 48; i++) ks[n][i] = cd[PC2_T[i-1]];
    end
    for (int unsigned i = 1; i <= 64; i++) x[i] = blk[IP_T[i-1]];
    lh = x[1:32];
    rh = x[33:64];
    for (int unsigned n = 0; n < 16; n++) begin
      for (int unsigned i = 1; i <= 48; i++) t[i] = rh[E_T[i-1]] ^ (e ? ks[n][i] : ks[15-n][i]);
      for (int unsigned j = 0; j < 8; j++) begin
        row = 2*int'(t[6*j+1]) + int'(t[6*j+6]);
        col = 8*int'(t[6*j+2]) + 4*int'(t[6*j+3]) + 2*int'(t[6*j+4]) + int'(t[6*j+5]);
        sv[4*j+1 +: 4] = 4'(SBOX[j][row*16+col]);
      end
      for (int unsigned i = 1; i <= 32; i++) fo[i] = sv[P_T[i-1]];
      {lh, rh} = {rh, lh ^ fo};
    end
    pre = {rh, lh};
    for (int unsigned i = 1; i <= 64; i++) o[i] = pre[FP_T[i-1]];
    return o;
  endfunction

  function automatic logic [1:64] tdea(input bit e, input logic [1:64] a, b, c, input logic [1:64] blk);
    if (e) return des(des(des(blk, a, 1'b1), b, 1'b0), c, 1'b1);
    return des(des(des(blk, c, 1'b0), b, 1'b1), a, 1'b0);
  endfunction

  // Transaction model: result computed at load, published after 48 enabled edges.
  logic [1:64] m_k1, m_k2, m_k3, m_res, m_dout;
  logic        m_bsy, m_dvld;
  int          m_left;

  initial begin
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_k1 = '0; m_k2 = '0; m_k3 = '0;
        m_dout = '0; m_bsy = 1'b0; m_dvld = 1'b0; m_left = 0;
      end else if (EN) begin
        m_dvld = 1'b0;
        if (!m_bsy) begin
          if (Krdy) begin m_k1 = Key1; m_k2 = Key2; m_k3 = Key3; end
          if (Drdy) begin
            m_res  = tdea(ENC, m_k1, m_k2, m_k3, Din);
            m_left = 48;
            m_bsy  = 1'b1;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_bsy  = 1'b0;
            m_dvld = 1'b1;
            m_dout = m_res;
          end
        end
      end
    end
  end

  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      check("cyc_bsy",  64'(BSY),  64'(m_bsy));
      check("cyc_dvld", 64'(Dvld), 64'(m_dvld));
      check("cyc_dout", Dout, m_dout);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic load_keys(input logic [1:64] a, b, c);
    Key1 = a; Key2 = b; Key3 = c; Krdy = 1'b1;
    tick();
    Krdy = 1'b0;
  endtask

  task automatic run_block(input bit e, input logic [1:64] din, input int stall, input bit poke,
                           output logic [1:64] res, output int lat);
    logic got;
    Din = din; ENC = e; Drdy = 1'b1;
    tick();
    Drdy = 1'b0; Krdy = 1'b0;
    Din = {$urandom(), $urandom()};
    got = 1'b0; lat = 0; res = '0;
    for (int n = 0; n < 200; n++) begin
      if (poke && n == 10) begin
        Key1 = {$urandom(), $urandom()}; Key2 = {$urandom(), $urandom()};
        Key3 = {$urandom(), $urandom()}; Krdy = 1'b1; Drdy = 1'b1; ENC = ~e;
      end
      if (n == 11) begin Krdy = 1'b0; Drdy = 1'b0; end
      if (stall > 0 && n == 20) EN = 1'b0;
      if (n == 20 + stall) EN = 1'b1;
      tick();
      lat++;
      if (Dvld) begin
        res = Dout;
        got = 1'b1;
        break;
      end
    end
    check("dvld_seen", 64'(got), 64'd1);
  endtask

  localparam logic [1:64] KA = 64'h10316E028C8F3B4A;
  localparam logic [1:64] KB = 64'h0123456789ABCDEF;
  localparam logic [1:64] KC = 64'h133457799BBCDFF1;

  initial begin
    logic [1:64] res, res2, a, b, c, din;
    int lat, lat2, stall, nv;
    RST = 1'b1; EN = 1'b1; Krdy = 1'b0; Drdy = 1'b0; ENC = 1'b0;
    Din = '0; Key1 = '0; Key2 = '0; Key3 = '0;
    tick(); tick();
    RST = 1'b0;
    check("rst_dout", Dout, 64'd0);
    check("rst_bsy",  64'(BSY), 64'd0);
    check("rst_dvld", 64'(Dvld), 64'd0);

    check("model_kat_a", tdea(1'b1, KA, KA, KA, 64'd0), 64'h82DCBAFBDEAB6602);
    check("model_kat_b", des(64'h4E6F772069732074, KB, 1'b1), 64'h3FA40E8A984D4815);
    check("model_kat_c", des(KB, KC, 1'b1), 64'h85E813540F0AB405);
    check("model_kat_c_dec", des(64'h85E813540F0AB405, KC, 1'b0), KB);

    load_keys(KA, KA, KA);
    run_block(1'b1, 64'd0, 0, 1'b0, res, lat);
    check("kat_a_enc", res, 64'h82DCBAFBDEAB6602);
    check("kat_a_latency", 64'(lat), 64'd48);
    run_block(1'b0, 64'h82DCBAFBDEAB6602, 0, 1'b0, res, lat);
    check("kat_a_dec", res, 64'd0);

    Key1 = KB; Key2 = KB; Key3 = KB; Krdy = 1'b1;
    run_block(1'b1, 64'h4E6F772069732074, 0, 1'b0, res, lat);
    check("krdy_drdy_same_cycle", res, 64'h3FA40E8A984D4815);

    load_keys(KC, KC, KC);
    run_block(1'b1, KB, 0, 1'b0, res, lat);
    check("kat_c_enc", res, 64'h85E813540F0AB405);
    run_block(1'b1, KB, 0, 1'b1, res, lat);
    check("poke_result", res, 64'h85E813540F0AB405);
    check("poke_latency", 64'(lat), 64'd48);
    run_block(1'b1, KB, 0, 1'b0, res, lat);
    check("poke_keys_kept", res, 64'h85E813540F0AB405);
    run_block(1'b1, KB, 5, 1'b0, res, lat);
    check("stall_result", res, 64'h85E813540F0AB405);
    check("stall_latency", 64'(lat), 64'd53);

    for (int it = 0; it < 6; it++) begin
      a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
      c = {$urandom(), $urandom()}; din = {$urandom(), $urandom()};
      stall = (it % 3 == 1) ? int'($urandom_range(1, 7)) : 0;
      load_keys(a, b, c);
      run_block(1'b1, din, stall, it[0], res, lat);
      check("rand_enc", res, tdea(1'b1, a, b, c, din));
      check("rand_enc_latency", 64'(lat), 64'(48 + stall));
      run_block(1'b0, res, 0, 1'b0, res2, lat2);
      check("rand_roundtrip", res2, din);
    end

    load_keys(KA, KB, KC);
    Din = 64'h0011223344556677; ENC = 1'b1; Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    repeat (20) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_bsy",  64'(BSY), 64'd0);
    check("abort_dout", Dout, 64'd0);
    nv = 0;
    repeat (60) begin
      tick();
      if (Dvld) nv++;
    end
    check("abort_no_dvld", 64'(nv), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
